// File: rtl/seq_mul_nbit.sv
// Shift-add sequential multiplier: N-bit operands, per-operation signed/unsigned mode,
// start/ready handshake, one-cycle done pulse and a held 2N-bit product register.
module seq_mul_nbit #(
  parameter int WIDTH     = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q;
  logic                 mode_q;
  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     mq_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH:0]       a_ext;
  logic                 use_sub;
  logic                 last_bit;
  logic [WIDTH:0]       acc_add;
  logic [2*WIDTH:0]     shifted;

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ADD;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = last_bit ? S_DONE : S_ADD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The multiplier's top bit carries negative weight in two's complement, so the
  // final partial product is subtracted rather than added in signed mode.
  always_comb begin
    last_bit = (cnt_q == CNT_W'(1));
    a_ext    = mode_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    use_sub  = mode_q && last_bit;
    acc_add  = use_sub ? (acc_q - a_ext) : (acc_q + a_ext);
    shifted  = {acc_q, mq_q} >> 1;
    // Signed mode needs an arithmetic shift; unsigned the carry already sits in acc_q[WIDTH].
    shifted[2*WIDTH] = mode_q ? acc_q[WIDTH] : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q    <= multiplicand_i;
            mq_q   <= multiplier_i;
            mode_q <= signed_i & (SIGNED_EN != 0);
            acc_q  <= '0;
            cnt_q  <= CNT_W'(WIDTH);
          end
        end
        S_ADD: begin
          if (mq_q[0]) acc_q <= acc_add;
        end
        S_SHIFT: begin
          acc_q <= shifted[2*WIDTH:WIDTH];
          mq_q  <= shifted[WIDTH-1:0];
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_bit) product_q <= shifted[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign product_o = product_q;

endmodule
